// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings and FSM state codes for the multiply/divide unit
package mdu_pkg;
  typedef logic [2:0] mdu_op_t;
  localparam mdu_op_t MDU_MULT  = 3'd0;
  localparam mdu_op_t MDU_MULTU = 3'd1;
  localparam mdu_op_t MDU_DIV   = 3'd2;
  localparam mdu_op_t MDU_DIVU  = 3'd3;
  localparam mdu_op_t MDU_MTHI  = 3'd4;
  localparam mdu_op_t MDU_MTLO  = 3'd5;
  localparam mdu_op_t MDU_MADD  = 3'd6;
  localparam mdu_op_t MDU_MADDU = 3'd7;
  localparam logic [0:0] MDU_IDLE = 1'b0;
  localparam logic [0:0] MDU_RUN  = 1'b1;
endpackage

// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if: request/result bundle between the E stage and the multiply/divide unit
interface mdu_hilo_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, op, a, b, input busy, hi, lo);
  modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mdu_divmod.sv
// mdu_divmod: combinational signed/unsigned quotient and remainder with zero-divisor flag
module mdu_divmod #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sgn,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dz
);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  logic             na, nb, ovf;
  logic [WIDTH-1:0] ua, ub, uq, ur;
  // divide magnitudes, then restore signs: quotient truncates toward zero, remainder follows dividend
  always_comb begin
    dz  = b == '0;
    na  = sgn & a[WIDTH-1];
    nb  = sgn & b[WIDTH-1];
    ovf = sgn && a == MOST_NEG && b == '1;
    ua  = na ? -a : a;
    ub  = dz ? ONE : nb ? -b : b;
    uq  = ua / ub;
    ur  = ua % ub;
    q   = ovf ? MOST_NEG : (na ^ nb) ? -uq : uq;
    r   = ovf ? '0 : na ? -ur : ur;
  end
endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle multiply/divide unit with HI/LO registers; MDU_MADD_EN enables MADD/MADDU
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_hilo_if.slave bus
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  logic [0:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] pend_q, pend_d;
  logic               wr_q, wr_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               acc, run, fin, is_mul, is_div, is_madd, multi, sgn, dz;
  logic [2*WIDTH-1:0] ax, bx, prod, mul_res;
  logic [WIDTH-1:0]   dq, dr;

  mdu_divmod #(.WIDTH(WIDTH)) u_divmod (
    .a  (bus.a),
    .b  (bus.b),
    .sgn(sgn),
    .q  (dq),
    .r  (dr),
    .dz (dz)
  );

  // decode the request, compute the full result up front and sequence the busy countdown
  always_comb begin
    run    = state_q == MDU_RUN;
    acc    = bus.start && !run;
    fin    = run && cnt_q == CW'(1);
    sgn    = ~bus.op[0];
    is_div = bus.op == MDU_DIV || bus.op == MDU_DIVU;
`ifdef MDU_MADD_EN
    is_madd = bus.op == MDU_MADD || bus.op == MDU_MADDU;
`else
    is_madd = 1'b0;
`endif
    is_mul  = bus.op == MDU_MULT || bus.op == MDU_MULTU || is_madd;
    multi   = acc && (is_mul || is_div);
    ax      = {{WIDTH{sgn & bus.a[WIDTH-1]}}, bus.a};
    bx      = {{WIDTH{sgn & bus.b[WIDTH-1]}}, bus.b};
    prod    = ax * bx;
`ifdef MDU_MADD_EN
    mul_res = is_madd ? {hi_q, lo_q} + prod : prod;
`else
    mul_res = prod;
`endif
    pend_d  = multi ? (is_div ? {dr, dq} : mul_res) : pend_q;
    wr_d    = multi ? !(is_div && dz) : wr_q;
    cnt_d   = multi ? (is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES)) : run ? cnt_q - CW'(1) : cnt_q;
    state_d = multi ? MDU_RUN : fin ? MDU_IDLE : state_q;
    hi_d    = fin && wr_q ? pend_q[2*WIDTH-1:WIDTH] : acc && bus.op == MDU_MTHI ? bus.a : hi_q;
    lo_d    = fin && wr_q ? pend_q[WIDTH-1:0] : acc && bus.op == MDU_MTLO ? bus.a : lo_q;
  end

  // state registers; an asserted reset cancels any in-flight operation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      wr_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      wr_q    <= wr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy = run;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: scoreboard bench for mdu_hilo at WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10
module tb_mdu_hilo;
  import mdu_pkg::*;
  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int n_chk  = 0;
  int n_pass = 0;
  logic [63:0] sb[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  mdu_hilo_if #(.WIDTH(W)) bus ();
  mdu_hilo #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int lat_of(input logic [2:0] op);
    if (op == MDU_MULT || op == MDU_MULTU) return MC;
    if (op == MDU_DIV || op == MDU_DIVU) return DC;
`ifdef MDU_MADD_EN
    if (op == MDU_MADD || op == MDU_MADDU) return MC;
`endif
    return 0;
  endfunction

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r = {m_hi, m_lo};
    int sa = a;
    int sb_ = b;
    case (op)
      MDU_MULT:  r = longint'(sa) * longint'(sb_);
      MDU_MULTU: r = {32'b0, a} * {32'b0, b};
      MDU_DIV: begin
        if (b == 0) r = {m_hi, m_lo};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'h0, 32'h80000000};
        else r = {32'(sa % sb_), 32'(sa / sb_)};
      end
      MDU_DIVU:  if (b != 0) r = {a % b, a / b};
      MDU_MTHI:  r[63:32] = a;
      MDU_MTLO:  r[31:0] = a;
`ifdef MDU_MADD_EN
      MDU_MADD:  r = {m_hi, m_lo} + 64'(longint'(sa) * longint'(sb_));
      MDU_MADDU: r = {m_hi, m_lo} + {32'b0, a} * {32'b0, b};
`endif
      default: ;
    endcase
    return r;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int lat = lat_of(op);
    int cyc = 0;
    logic [63:0] e;
    sb.push_back(model(op, a, b));
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    while (bus.busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, "_busy"}, 64'(cyc), 64'(lat));
    e = sb.pop_front();
    check({tag, "_hilo"}, {bus.hi, bus.lo}, e);
    {m_hi, m_lo} = e;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [63:0] e;
    bus.start = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    #2 reset = 1'b0;
    #10;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op("mult", MDU_MULT, 32'hFFFFFFFF, 32'd2);
    run_op("multu", MDU_MULTU, 32'hFFFFFFFF, 32'd2);
    run_op("div_neg", MDU_DIV, 32'hFFFFFFF9, 32'd2);
    run_op("div_ovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF);
    run_op("divu", MDU_DIVU, 32'd100, 32'd7);
    run_op("div_mix", MDU_DIV, 32'd7, 32'hFFFFFFFE);
    run_op("mthi", MDU_MTHI, 32'h12345678, 32'd0);
    run_op("mtlo", MDU_MTLO, 32'hCAFEF00D, 32'd0);
    run_op("divu_z", MDU_DIVU, 32'd55, 32'd0);
    run_op("div_z", MDU_DIV, 32'hFFFFFFF0, 32'd0);

    // MTLO requests held high throughout a MULT must all be ignored, including at the exit edge
    sb.push_back(model(MDU_MULT, 32'd3, 32'hFFFFFFFB));
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = MDU_MULT;
    bus.a = 32'd3;
    bus.b = 32'hFFFFFFFB;
    @(negedge clk);
    bus.op = MDU_MTLO;
    bus.a = 32'hAA;
    cyc = 0;
    while (bus.busy && cyc < 200) begin
      check("spam_lo", 64'(bus.lo), 64'(m_lo));
      cyc++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("spam_busy", 64'(cyc), 64'(MC));
    e = sb.pop_front();
    check("spam_hilo", {bus.hi, bus.lo}, e);
    {m_hi, m_lo} = e;
    @(negedge clk);
    check("spam_after", {bus.hi, bus.lo}, e);

    run_op("acc_hi", MDU_MTHI, 32'd0, 32'd0);
    run_op("acc_lo", MDU_MTLO, 32'hFFFFFFFF, 32'd0);
    run_op("maddu", MDU_MADDU, 32'd1, 32'd1);
    run_op("madd", MDU_MADD, 32'hFFFFFFFF, 32'd3);

    for (int i = 0; i < 8; i++) begin
      logic [2:0] op = 3'($urandom_range(0, 3));
      logic [31:0] ra = $urandom;
      logic [31:0] rb = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      run_op("rand", op, ra, rb);
    end

    run_op("pre_rst", MDU_MULTU, 32'h00010001, 32'h00030007);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = MDU_DIV;
    bus.a = 32'd1000;
    bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_hilo", {bus.hi, bus.lo}, 64'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    check("post_rst_busy", 64'(bus.busy), 64'd0);
    check("post_rst_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});

    run_op("after_rst", MDU_MULT, 32'h80000000, 32'h80000000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
